// File: rtl/id_ex_pkg.sv
// Shared opcode constants and helpers for the decode/execute boundary.
//   OP_NOP          : bubble opcode, distinct from every ALU opcode
//   OP_ADD..OP_STW  : opcodes this stage has to recognise or pass through
//   is_load()       : true for opcodes whose result arrives late (from MEM)
package id_ex_pkg;

  localparam int unsigned OpWidth = 14;

  typedef logic [OpWidth-1:0] op_t;

  localparam op_t OP_NOP = 14'h0000;
  localparam op_t OP_ADD = 14'h0001;
  localparam op_t OP_LDB = 14'h0100;
  localparam op_t OP_LDW = 14'h0200;
  localparam op_t OP_STB = 14'h0400;
  localparam op_t OP_STW = 14'h0800;

  function automatic logic is_load(input op_t op);
    return (op == OP_LDB) || (op == OP_LDW);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux for one source register.
//   idx / used / rf_val : source index, read-enable and register-file data
//   mem_fwd_*           : MEM-stage result (younger, highest priority)
//   wb_fwd_*            : WB-stage result
//   data                : selected operand value
module fwd_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] idx,
  input  logic              used,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic [DATA_W-1:0] data
);

  logic mem_hit;
  logic wb_hit;

  // An unread source's value is don't-care, so skipping the match there is harmless.
  // r0 is hardwired zero and never takes a forwarded value.
  always_comb begin
    mem_hit = used && mem_fwd_valid && (mem_fwd_rd != '0) && (mem_fwd_rd == idx);
    wb_hit  = used && wb_fwd_valid && (wb_fwd_rd != '0) && (wb_fwd_rd == idx);
    data    = rf_val;
    if (mem_hit) begin
      data = mem_fwd_data;
    end else if (wb_hit) begin
      data = wb_fwd_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding and load-use bubble insertion.
//   id_*          : decoded instruction presented by decode; id_ready grants advance
//   mem_fwd_*     : MEM-stage result available for forwarding
//   wb_fwd_*      : WB-stage result available for forwarding
//   stall_in      : downstream freeze (holds every register)
//   flush         : kill the EX slot (overrides stall_in)
//   ex_*          : registered EX-slot contents; ex_op/ex_x/ex_y feed the ALU
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 14,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_AW-1:0] id_rs1_idx,
  input  logic [REG_AW-1:0] id_rs2_idx,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [DATA_W-1:0] id_rs1_val,
  input  logic [DATA_W-1:0] id_rs2_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd_idx,
  output logic              id_ready,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic              stall_in,
  input  logic              flush,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_x,
  output logic [DATA_W-1:0] ex_y,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd
);

  localparam logic [OP_W-1:0] Nop = OP_W'(OP_NOP);

  logic              ex_valid_q;
  logic [OP_W-1:0]   ex_op_q;
  logic [DATA_W-1:0] ex_x_q;
  logic [DATA_W-1:0] ex_y_q;
  logic [DATA_W-1:0] ex_store_data_q;
  logic [REG_AW-1:0] ex_rd_q;

  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;
  logic              load_use;

  fwd_mux #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rs1 (
    .idx          (id_rs1_idx),
    .used         (id_rs1_used),
    .rf_val       (id_rs1_val),
    .mem_fwd_valid(mem_fwd_valid),
    .mem_fwd_rd   (mem_fwd_rd),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_valid (wb_fwd_valid),
    .wb_fwd_rd    (wb_fwd_rd),
    .wb_fwd_data  (wb_fwd_data),
    .data         (rs1_fwd)
  );

  fwd_mux #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rs2 (
    .idx          (id_rs2_idx),
    .used         (id_rs2_used),
    .rf_val       (id_rs2_val),
    .mem_fwd_valid(mem_fwd_valid),
    .mem_fwd_rd   (mem_fwd_rd),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_valid (wb_fwd_valid),
    .wb_fwd_rd    (wb_fwd_rd),
    .wb_fwd_data  (wb_fwd_data),
    .data         (rs2_fwd)
  );

  // A load in EX cannot forward its data yet; the dependent instruction waits one cycle
  // and then picks the value up from the MEM forward port.
  always_comb begin
    load_use = ex_valid_q && is_load(op_t'(ex_op_q)) && (ex_rd_q != '0) && id_valid &&
               ((id_rs1_used && (id_rs1_idx == ex_rd_q)) ||
                (id_rs2_used && (id_rs2_idx == ex_rd_q)));
    id_ready = !stall_in && !load_use && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_op_q         <= Nop;
      ex_x_q          <= '0;
      ex_y_q          <= '0;
      ex_store_data_q <= '0;
      ex_rd_q         <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= Nop;
    end else if (stall_in) begin
      // Hold; MEM/WB are frozen too, so held operands remain correct.
    end else if (load_use) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= Nop;
    end else begin
      ex_valid_q      <= id_valid;
      ex_op_q         <= id_valid ? id_op : Nop;
      ex_x_q          <= rs1_fwd;
      ex_y_q          <= id_use_imm ? id_imm : rs2_fwd;
      ex_store_data_q <= rs2_fwd;
      ex_rd_q         <= id_rd_idx;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_op         = ex_op_q;
  assign ex_x          = ex_x_q;
  assign ex_y          = ex_y_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_rd         = ex_rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of directed vectors plus hand-written
// reset sequences.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [13:0] id_op;
  logic [4:0]  id_rs1_idx, id_rs2_idx;
  logic        id_rs1_used, id_rs2_used;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm;
  logic        id_use_imm;
  logic [4:0]  id_rd_idx;
  logic        id_ready;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        stall_in, flush;
  logic        ex_valid;
  logic [13:0] ex_op;
  logic [31:0] ex_x, ex_y, ex_store_data;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W(32),
    .OP_W  (14),
    .REG_AW(5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_op        (id_op),
    .id_rs1_idx   (id_rs1_idx),
    .id_rs2_idx   (id_rs2_idx),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rs1_val   (id_rs1_val),
    .id_rs2_val   (id_rs2_val),
    .id_imm       (id_imm),
    .id_use_imm   (id_use_imm),
    .id_rd_idx    (id_rd_idx),
    .id_ready     (id_ready),
    .mem_fwd_valid(mem_fwd_valid),
    .mem_fwd_rd   (mem_fwd_rd),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_valid (wb_fwd_valid),
    .wb_fwd_rd    (wb_fwd_rd),
    .wb_fwd_data  (wb_fwd_data),
    .stall_in     (stall_in),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_x         (ex_x),
    .ex_y         (ex_y),
    .ex_store_data(ex_store_data),
    .ex_rd        (ex_rd)
  );

  typedef struct packed {
    logic        valid;
    logic [13:0] op;
    logic [4:0]  rs1;
    logic        u1;
    logic [31:0] v1;
    logic [4:0]  rs2;
    logic        u2;
    logic [31:0] v2;
    logic [31:0] imm;
    logic        ui;
    logic [4:0]  rd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        stall;
    logic        fl;
    logic        e_ready;
    logic        e_valid;
    logic [13:0] e_op;
    logic [31:0] e_x;
    logic [31:0] e_y;
    logic [31:0] e_sd;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t ins(input logic [13:0] op, input logic [4:0] rs1,
                               input logic [31:0] v1, input logic [4:0] rs2,
                               input logic [31:0] v2, input logic [4:0] rd);
    vec_t v;
    v       = '0;
    v.valid = 1'b1;
    v.op    = op;
    v.rs1   = rs1;
    v.u1    = 1'b1;
    v.v1    = v1;
    v.rs2   = rs2;
    v.u2    = 1'b1;
    v.v2    = v2;
    v.rd    = rd;
    return v;
  endfunction

  function automatic vec_t exp_of(input vec_t vi, input logic rdy, input logic vld,
                                  input logic [13:0] op, input logic [31:0] x,
                                  input logic [31:0] y, input logic [31:0] sd,
                                  input logic [4:0] rd);
    vec_t v;
    v         = vi;
    v.e_ready = rdy;
    v.e_valid = vld;
    v.e_op    = op;
    v.e_x     = x;
    v.e_y     = y;
    v.e_sd    = sd;
    v.e_rd    = rd;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_valid      = v.valid;
    id_op         = v.op;
    id_rs1_idx    = v.rs1;
    id_rs1_used   = v.u1;
    id_rs1_val    = v.v1;
    id_rs2_idx    = v.rs2;
    id_rs2_used   = v.u2;
    id_rs2_val    = v.v2;
    id_imm        = v.imm;
    id_use_imm    = v.ui;
    id_rd_idx     = v.rd;
    mem_fwd_valid = v.mv;
    mem_fwd_rd    = v.mrd;
    mem_fwd_data  = v.md;
    wb_fwd_valid  = v.wv;
    wb_fwd_rd     = v.wrd;
    wb_fwd_data   = v.wd;
    stall_in      = v.stall;
    flush         = v.fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ex_valid"}, 32'(ex_valid), 32'h0);
    chk({tag, " ex_op"}, 32'(ex_op), 32'(OP_NOP));
    chk({tag, " ex_x"}, ex_x, 32'h0);
    chk({tag, " ex_y"}, ex_y, 32'h0);
    chk({tag, " ex_store_data"}, ex_store_data, 32'h0);
    chk({tag, " ex_rd"}, 32'(ex_rd), 32'h0);
  endtask

  initial begin
    vec_t v;

    // Table: each row is driven at a negedge; id_ready checked before the edge,
    // registered outputs checked just after it.
    v = ins(OP_ADD, 5'd1, 32'h5, 5'd2, 32'h7, 5'd6);
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'h5, 32'h7, 32'h7, 5'd6));
    // MEM beats WB on the same register
    v = ins(OP_ADD, 5'd3, 32'h11, 5'd2, 32'h7, 5'd7);
    v.mv = 1'b1; v.mrd = 5'd3; v.md = 32'hAAAA;
    v.wv = 1'b1; v.wrd = 5'd3; v.wd = 32'hBBBB;
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'hAAAA, 32'h7, 32'h7, 5'd7));
    v.mv = 1'b0;
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'hBBBB, 32'h7, 32'h7, 5'd7));
    // r0 never forwards, even with forward ports naming r0
    v = ins(OP_ADD, 5'd0, 32'h22, 5'd2, 32'h7, 5'd8);
    v.mv = 1'b1; v.mrd = 5'd0; v.md = 32'hAAAA;
    v.wv = 1'b1; v.wrd = 5'd0; v.wd = 32'hBBBB;
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'h22, 32'h7, 32'h7, 5'd8));
    // rs1 from WB, rs2 from MEM
    v = ins(OP_ADD, 5'd5, 32'h1, 5'd6, 32'h2, 5'd9);
    v.mv = 1'b1; v.mrd = 5'd6; v.md = 32'hC;
    v.wv = 1'b1; v.wrd = 5'd5; v.wd = 32'hD;
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'hD, 32'hC, 32'hC, 5'd9));
    // Load into r4, then dependent ADD stalls one cycle, then takes MEM forward
    v = ins(OP_LDW, 5'd1, 32'h100, 5'd2, 32'h7, 5'd4);
    v.ui = 1'b1; v.imm = 32'h8;
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_LDW, 32'h100, 32'h8, 32'h7, 5'd4));
    v = ins(OP_ADD, 5'd1, 32'h5, 5'd4, 32'h99, 5'd9);
    tbl.push_back(exp_of(v, 1'b0, 1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0));
    v.mv = 1'b1; v.mrd = 5'd4; v.md = 32'h1234;
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'h5, 32'h1234, 32'h1234, 5'd9));
    // Load to r3; an unused rs1 matching r3 is not a hazard
    v = ins(OP_LDB, 5'd1, 32'h10, 5'd2, 32'h20, 5'd3);
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_LDB, 32'h10, 32'h20, 32'h20, 5'd3));
    v = ins(OP_ADD, 5'd3, 32'h30, 5'd2, 32'h40, 5'd10);
    v.u1 = 1'b0;
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'h30, 32'h40, 32'h40, 5'd10));
    // Load to r0 is never a hazard
    v = ins(OP_LDW, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0);
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_LDW, 32'h1, 32'h2, 32'h2, 5'd0));
    v = ins(OP_ADD, 5'd0, 32'h3, 5'd0, 32'h4, 5'd11);
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'h3, 32'h4, 32'h4, 5'd11));
    // Store: y takes the immediate, store data forwarded from WB
    v = ins(OP_STW, 5'd1, 32'h200, 5'd5, 32'h1, 5'd0);
    v.ui = 1'b1; v.imm = 32'h8;
    v.wv = 1'b1; v.wrd = 5'd5; v.wd = 32'h55;
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_STW, 32'h200, 32'h8, 32'h55, 5'd0));
    // id_valid=0 captures a bubble
    v = '0;
    tbl.push_back(exp_of(v, 1'b1, 1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0));
    // Flush kills the slot
    v = ins(OP_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 5'd12);
    v.fl = 1'b1;
    tbl.push_back(exp_of(v, 1'b0, 1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0));
    // Capture, then stall three cycles with changing inputs
    v = ins(OP_ADD, 5'd1, 32'h77, 5'd2, 32'h7, 5'd2);
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'h77, 32'h7, 32'h7, 5'd2));
    for (int i = 0; i < 3; i++) begin
      v = ins(OP_LDW, 5'd3, 32'h5 + 32'(i), 5'd4, 32'h6, 5'd13);
      v.stall = 1'b1; v.mv = 1'b1; v.mrd = 5'd1; v.md = 32'hF;
      tbl.push_back(exp_of(v, 1'b0, 1'b1, OP_ADD, 32'h77, 32'h7, 32'h7, 5'd2));
    end
    // Flush overrides stall; a held bubble stays a bubble
    v = ins(OP_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 5'd14);
    v.stall = 1'b1; v.fl = 1'b1;
    tbl.push_back(exp_of(v, 1'b0, 1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0));
    v.fl = 1'b0;
    tbl.push_back(exp_of(v, 1'b0, 1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0));
    v = ins(OP_ADD, 5'd1, 32'h8, 5'd2, 32'h9, 5'd15);
    tbl.push_back(exp_of(v, 1'b1, 1'b1, OP_ADD, 32'h8, 32'h9, 32'h9, 5'd15));

    // Reset
    rst_n = 1'b0;
    apply('0);
    @(posedge clk);
    #1;
    n_vec++;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset id_ready", 32'(id_ready), 32'h1);

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      n_vec++;
      chk($sformatf("row%0d id_ready", i), 32'(id_ready), 32'(tbl[i].e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d ex_op", i), 32'(ex_op), 32'(tbl[i].e_op));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d ex_x", i), ex_x, tbl[i].e_x);
        chk($sformatf("row%0d ex_y", i), ex_y, tbl[i].e_y);
        chk($sformatf("row%0d ex_store_data", i), ex_store_data, tbl[i].e_sd);
        chk($sformatf("row%0d ex_rd", i), 32'(ex_rd), 32'(tbl[i].e_rd));
      end
    end

    // Async reset with a load-use hazard pending: clear is immediate, hazard is gone
    @(negedge clk);
    apply(ins(OP_LDW, 5'd1, 32'h1, 5'd2, 32'h2, 5'd4));
    @(posedge clk);
    #1;
    n_vec++;
    chk("pre-reset load ex_op", 32'(ex_op), 32'(OP_LDW));
    @(negedge clk);
    apply(ins(OP_ADD, 5'd1, 32'h1, 5'd4, 32'h2, 5'd9));
    #1;
    chk("pre-reset hazard id_ready", 32'(id_ready), 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk_reset_state("async");
    chk("async id_ready", 32'(id_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk("post-reset ex_valid", 32'(ex_valid), 32'h1);
    chk("post-reset ex_op", 32'(ex_op), 32'(OP_ADD));
    chk("post-reset ex_y", ex_y, 32'h2);
    chk("post-reset ex_rd", 32'(ex_rd), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the execute-stage ALU.
- Captures the decoded op, operands and destination, and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts one bubble into EX while holding decode.
- Its outputs ex_op, ex_x and ex_y drive the ALU op, x and y inputs directly.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 14, opcode width; matches the ALU op port.
- REG_AW, 5, register index width; register 0 is hardwired zero.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_op  in  OP_W  decoded opcode.
- id_rs1_idx, id_rs2_idx  in  REG_AW  source register indices.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rs1_val, id_rs2_val  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_use_imm  in  1  y takes id_imm instead of rs2.
- id_rd_idx  in  REG_AW  destination register.
- id_ready  out  1  decode may advance this cycle.
- mem_fwd_valid  in  1  MEM-stage result is final and writes a register.
- mem_fwd_rd  in  REG_AW  MEM-stage destination.
- mem_fwd_data  in  DATA_W  MEM-stage result.
- wb_fwd_valid, wb_fwd_rd, wb_fwd_data  in  1/REG_AW/DATA_W  same meaning for the WB stage.
- stall_in  in  1  downstream freeze.
- flush  in  1  kill the EX slot (branch/jump/iret redirect).
- ex_valid  out  1  EX slot holds a valid instruction.
- ex_op  out  OP_W  opcode to the ALU.
- ex_x, ex_y  out  DATA_W  ALU operands.
- ex_store_data  out  DATA_W  forwarded rs2 value for STB/STW.
- ex_rd  out  REG_AW  destination register.

Behaviour:
- Reset (async assert, synchronous release): ex_valid=0, ex_op=`NOP, ex_x=ex_y=ex_store_data=0, ex_rd=0.
- Latency: one cycle from decode presentation to EX outputs. All outputs are registered except id_ready.
- Forward select per source s (rs1, rs2), evaluated combinationally at capture:
  - If mem_fwd_valid && mem_fwd_rd!=0 && mem_fwd_rd==idx_s: mem_fwd_data.
  - Else if the same test passes for WB: wb_fwd_data.
  - Else: id_rs*_val.
  - MEM wins over WB because it is younger.
  - idx 0 never forwards; an id_rs*_val of zero is passed through as-is.
- Operand mapping:
  - ex_x = fwd(rs1).
  - ex_y = id_use_imm ? id_imm : fwd(rs2).
  - ex_store_data = fwd(rs2), always.
- Load-use detection (combinational), load_use=1 when all hold:
  - ex_valid, and ex_op is `LDB or `LDW, and ex_rd!=0, and id_valid;
  - and (id_rs1_used && id_rs1_idx==ex_rd) or (id_rs2_used && id_rs2_idx==ex_rd).
- id_ready = !stall_in && !load_use && !flush.
- Clock-edge update, in priority order:
  1. flush: ex_valid<=0, ex_op<=`NOP. Flush overrides stall_in.
  2. stall_in: hold every register, including an existing bubble.
  3. load_use: insert a bubble (ex_valid<=0, ex_op<=`NOP). Decode holds, so the instruction is re-presented next cycle and the load's data arrives through the MEM forward.
  4. Otherwise capture: ex_valid<=id_valid, plus op, operands and rd. When id_valid=0, capture a bubble with ex_op=`NOP.
- Bubble data: on a bubble, ex_x, ex_y and ex_store_data may hold stale values. The verifier checks them only when ex_valid=1.
- Stall semantics: stall_in assumes MEM/WB are frozen too, so held operands stay correct. No re-forwarding is done while held.
- Reset mid-stall or mid-bubble: the asynchronous clear wins immediately and no pending hazard survives it.

Decomposition:
- CONSTANTS.vh: add `NOP (14'h0000, not equal to any ALU opcode). Reuse the existing `LDB, `LDW, `STB, `STW and `X32.
- Sub-module fwd_mux: one per source. Inputs are idx, used, regfile value and both forward ports; output is the selected data. Instantiated twice.

Test Plan:
- Plain capture: id_op=`ADD, rs1_val=5, rs2_val=7, no forwards → next cycle ex_valid=1, ex_x=5, ex_y=7, ex_rd as given.
- Forward priority: rs1=3, mem_fwd rd=3 data=0xAAAA, wb_fwd rd=3 data=0xBBBB → ex_x=0xAAAA. Repeat with mem_fwd_valid=0 → 0xBBBB. Repeat with rs1=0 → regfile value.
- Load-use: EX holds `LDW rd=4; decode `ADD rs2=4 → id_ready=0 and a bubble next cycle. Then mem_fwd rd=4 data=0x1234 → ADD captured with ex_y=0x1234.
- Immediate/store: `STW, use_imm=1, imm=8, rs2 forwarded from WB as 0x55 → ex_y=8, ex_store_data=0x55.
- Control priority: stall_in=1 for 3 cycles → outputs constant. flush and stall_in together → ex_valid=0, ex_op=`NOP.
- Async reset mid-operation: drop rst_n between clock edges → all outputs at reset values before the next edge.
